// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter and sequencer in front of a shared N-to-1 mux datapath.
// A rotating priority pointer picks the next requester. A bounded hold time
// stops one requester from starving the others while they wait. The block
// drives the mux select, a one-hot grant vector and the selected data word.
//
// Parameters:
//   NREQ     - number of requesters, legal 2..8 (non-power-of-2 allowed).
//   DW       - data width per requester.
//   MAX_HOLD - maximum consecutive grant cycles while another requester
//              waits; 0 means unlimited.
//
// Ports:
//   clk    in   1             rising-edge clock
//   reset  in   1             synchronous, active-high reset
//   req    in   NREQ          request per requester, held until served
//   din    in   NREQ*DW       packed data, requester i at din[i*DW +: DW]
//   gnt    out  NREQ          one-hot grant (registered)
//   sel    out  clog2(NREQ)   binary index of the granted requester (registered)
//   valid  out  1             a grant is active (registered)
//   dout   out  DW            din slice of sel while valid, else 0
//   lock   in   1             only with ARB_LOCK_EN: suppresses preemption
//
// Build option:
//   ARB_LOCK_EN - when defined, adds the lock input. While valid and lock are
//                 both high the hold-time preemption is suppressed. Release
//                 still hands the grant over normally.
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int NREQ     = 8,
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      din,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] sel,
    output logic                    valid,
    output logic [DW-1:0]           dout
`ifdef ARB_LOCK_EN
    ,
    input  logic                    lock
`endif
);

    // -------------------------------------------------------------------------
    // Widths and constants
    // -------------------------------------------------------------------------
    localparam int SW = $clog2(NREQ);
    // The hold counter needs to reach MAX_HOLD. It stays at least one bit
    // wide so that it exists even when MAX_HOLD is 0 (unlimited).
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // Scan arithmetic holds start + offset, which can reach 2*NREQ-1.
    localparam int CW = SW + 2;

    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [CW-1:0] NREQ_C   = CW'(NREQ);
    localparam logic [SW-1:0] PTR_INIT = SW'(NREQ - 1);

    // FSM encoding
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]    state;
    logic [SW-1:0] ptr;        // last winner; the scan starts just above it
    logic [HW-1:0] hold_cnt;   // cycles the current owner has held the grant

    // -------------------------------------------------------------------------
    // Winner selection
    //
    // The request vector is rotated so that index (base+1) lands at bit 0.
    // The lowest set bit of the rotated vector is the round-robin winner.
    // Adding the start back and folding modulo NREQ gives the real index.
    // Because the rotation only shifts real req bits, no select code at or
    // above NREQ can ever be produced.
    // -------------------------------------------------------------------------
    logic [SW-1:0]   scan_base;
    logic [CW-1:0]   scan_start;
    logic [NREQ-1:0] req_rot;
    logic [CW-1:0]   rot_off;
    logic            found;
    logic [SW-1:0]   winner;
    logic [NREQ-1:0] winner_oh;

    function automatic logic [SW-1:0] fold_index(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = (v >= NREQ_C) ? (v - NREQ_C) : v;
        return SW'(r);
    endfunction

    // In GRANT the scan starts above the current owner. In IDLE it starts
    // above the last winner, which after reset is NREQ-1, so requester 0
    // has top priority on the first arbitration.
    assign scan_base  = (state == GRANT) ? sel : ptr;
    assign scan_start = CW'(scan_base) + CW'(1);
    assign req_rot    = NREQ'({req, req} >> scan_start);
    assign found      = |req;

    always_comb begin
        // NOTE: every variable written here gets a default before the loop, so
        // no path leaves it unassigned and no latch is inferred.
        rot_off = '0;
        // Walk from the top down so that the lowest set bit is written last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_off = CW'(i);
            end
        end
    end

    assign winner    = fold_index(scan_start + rot_off);
    assign winner_oh = NREQ'(1) << winner;

    // -------------------------------------------------------------------------
    // Grant bookkeeping
    //
    // While a grant is active, gnt is exactly the one-hot of sel. Masking req
    // with gnt therefore gives the owner's request, and masking with ~gnt
    // gives everyone else's, without indexing req by a variable.
    // -------------------------------------------------------------------------
    logic owner_req;
    logic others_req;
    logic hold_full;
    logic lock_active;
    logic preempt;

    assign owner_req  = |(req & gnt);
    assign others_req = |(req & ~gnt);
    assign hold_full  = (hold_cnt == HOLD_MAX);

`ifdef ARB_LOCK_EN
    assign lock_active = valid & lock;
`else
    assign lock_active = 1'b0;
`endif

    assign preempt = (MAX_HOLD != 0) && hold_full && others_req && !lock_active;

    // -------------------------------------------------------------------------
    // Next-action decode
    //
    // Release is checked before preemption. When the owner drops req in the
    // same cycle that another requester raises it, the newcomer is granted
    // on that edge with no bubble.
    // -------------------------------------------------------------------------
    logic take_grant;
    logic go_idle;

    always_comb begin
        take_grant = 1'b0;
        go_idle    = 1'b0;
        case (state)
            IDLE: begin
                take_grant = found;
            end
            GRANT: begin
                if (!owner_req) begin
                    take_grant = found;
                    go_idle    = !found;
                end else if (preempt) begin
                    take_grant = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            // NOTE: reset is synchronous and overrides everything, including
            // a grant in progress; no partial grant survives the edge.
            state    <= IDLE;
            ptr      <= PTR_INIT;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
        end else if (take_grant) begin
            state    <= GRANT;
            ptr      <= winner;
            sel      <= winner;
            gnt      <= winner_oh;
            valid    <= 1'b1;
            hold_cnt <= HW'(1);
        end else if (go_idle) begin
            // sel keeps its last value; only gnt and valid drop.
            state <= IDLE;
            gnt   <= '0;
            valid <= 1'b0;
        end else if ((state == GRANT) && (MAX_HOLD != 0) && !hold_full) begin
            // The counter saturates so that a lone requester, or a locked
            // owner, can be preempted as soon as it becomes possible.
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Data mux
    //
    // A constant-bounded loop keeps every din slice in range for any NREQ,
    // including non-power-of-2 counts.
    // -------------------------------------------------------------------------
    always_comb begin
        dout = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (valid && (sel == SW'(i))) begin
                dout = din[i*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Self-checking bench for rr_mux_arbiter (NREQ=8, DW=4, MAX_HOLD=4).
// Directed scenarios compare against fixed expected values. A randomized
// scenario compares every cycle against a behavioural round-robin model that
// is written directly from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int NREQ     = 8;
    localparam int DW       = 4;
    localparam int MAX_HOLD = 4;
    localparam int SW       = $clog2(NREQ);

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   din;
    logic [NREQ-1:0]      gnt;
    logic [SW-1:0]        sel;
    logic                 valid;
    logic [DW-1:0]        dout;
    logic                 lock;

    logic [DW-1:0]        din_arr [NREQ];

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .dout  (dout)
`ifdef ARB_LOCK_EN
        ,
        .lock  (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        din = '0;
        for (int i = 0; i < NREQ; i++) din[i*DW +: DW] = din_arr[i];
    end

    // -------------------------------------------------------------------------
    // Behavioural reference model
    // -------------------------------------------------------------------------
    bit m_valid;
    int m_sel;
    int m_ptr;
    int m_hold;

    function automatic int rr_pick(input int base, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (base + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_valid = 1'b1;
        m_sel   = w;
        m_ptr   = w;
        m_hold  = 1;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step(input logic [NREQ-1:0] r, input logic rst, input logic lk);
        int w;
        int others;
        if (rst) begin
            m_valid = 1'b0;
            m_sel   = 0;
            m_ptr   = NREQ - 1;
            m_hold  = 0;
        end else if (!m_valid) begin
            w = rr_pick(m_ptr, r);
            if (w >= 0) model_grant(w);
        end else if (!r[m_sel]) begin
            w = rr_pick(m_sel, r);
            if (w >= 0) model_grant(w);
            else m_valid = 1'b0;
        end else begin
            others = 0;
            for (int i = 0; i < NREQ; i++) if (i != m_sel && r[i]) others++;
            if (MAX_HOLD != 0 && m_hold == MAX_HOLD && others > 0 && !lk) begin
                model_grant(rr_pick(m_sel, r));
            end else if (MAX_HOLD != 0 && m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) din_arr[i] = 4'hF;
        do_reset();
        checks++;
        if (gnt !== '0 || sel !== '0 || valid !== 1'b0 || dout !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt=%h sel=%0d valid=%b dout=%h, want 00/0/0/0",
                     gnt, sel, valid, dout);
        end
    endtask

    task automatic test_single_request();
        do_reset();
        for (int i = 0; i < NREQ; i++) din_arr[i] = DW'(i + 8);
        din_arr[0] = 4'h1;
        req = 8'h01;
        tick();
        checks++;
        if (gnt !== 8'h01 || sel !== 3'd0 || valid !== 1'b1 || dout !== 4'h1) begin
            errors++;
            $display("FAIL single_grant: gnt=%h sel=%0d valid=%b dout=%h, want 01/0/1/1",
                     gnt, sel, valid, dout);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt !== 8'h00 || valid !== 1'b0 || dout !== 4'h0) begin
            errors++;
            $display("FAIL single_release: gnt=%h valid=%b dout=%h, want 00/0/0",
                     gnt, valid, dout);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < NREQ; i++) din_arr[i] = DW'(i + 3);
        req = 8'h84;
        tick();
        checks++;
        if (gnt !== 8'h04 || sel !== 3'd2 || valid !== 1'b1 || dout !== 4'h5) begin
            errors++;
            $display("FAIL rotation_first: gnt=%h sel=%0d valid=%b dout=%h, want 04/2/1/5",
                     gnt, sel, valid, dout);
        end
        req = 8'h80;
        tick();
        checks++;
        if (gnt !== 8'h80 || sel !== 3'd7 || valid !== 1'b1 || dout !== 4'hA) begin
            errors++;
            $display("FAIL rotation_handover: gnt=%h sel=%0d valid=%b dout=%h, want 80/7/1/a",
                     gnt, sel, valid, dout);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt !== 8'h00 || sel !== 3'd7 || valid !== 1'b0) begin
            errors++;
            $display("FAIL rotation_idle_sel_hold: gnt=%h sel=%0d valid=%b, want 00/7/0",
                     gnt, sel, valid);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req = 8'hFF;
        for (int g = 0; g <= NREQ; g++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                logic [NREQ-1:0] exp_g;
                exp_g = NREQ'(1) << (g % NREQ);
                tick();
                checks++;
                if (gnt !== exp_g || valid !== 1'b1) begin
                    errors++;
                    $display("FAIL fairness g%0d c%0d: gnt=%h valid=%b, want %h/1",
                             g, c, gnt, valid, exp_g);
                end
            end
        end
    endtask

    task automatic test_lone_requester();
        do_reset();
        req = 8'h20;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h20 || sel !== 3'd5 || valid !== 1'b1) begin
                errors++;
                $display("FAIL lone c%0d: gnt=%h sel=%0d valid=%b, want 20/5/1",
                         c, gnt, sel, valid);
            end
        end
        // The counter is saturated by now, so a newcomer preempts at once.
        req = 8'h22;
        tick();
        checks++;
        if (gnt !== 8'h02 || sel !== 3'd1) begin
            errors++;
            $display("FAIL lone_then_preempt: gnt=%h sel=%0d, want 02/1", gnt, sel);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h20;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (gnt !== 8'h00 || valid !== 1'b0 || sel !== 3'd0 || dout !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_grant: gnt=%h sel=%0d valid=%b dout=%h, want 00/0/0/0",
                     gnt, sel, valid, dout);
        end
        req = 8'hFF;
        tick();
        checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_first_priority: gnt=%h sel=%0d, want 01/0", gnt, sel);
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req  = 8'hFF;
        lock = 1'b1;
        for (int c = 1; c < 10; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h01) begin
                errors++;
                $display("FAIL lock_hold c%0d: gnt=%h, want 01", c, gnt);
            end
        end
        lock = 1'b0;
        tick();
        checks++;
        if (gnt !== 8'h02) begin
            errors++;
            $display("FAIL lock_release: gnt=%h, want 02", gnt);
        end
    endtask
`endif

    task automatic test_random();
        logic [NREQ-1:0] nxt;
        logic [NREQ-1:0] exp_gnt;
        logic [DW-1:0]   exp_dout;
        do_reset();
        model_step('0, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 79) == 0);
`ifdef ARB_LOCK_EN
            lock = ($urandom_range(0, 2) == 0);
`else
            lock = 1'b0;
`endif
            for (int i = 0; i < NREQ; i++) din_arr[i] = DW'($urandom);
            nxt = req;
            for (int i = 0; i < NREQ; i++) begin
                if (m_valid && i == m_sel && req[i]) begin
                    if ($urandom_range(0, 3) == 0) nxt[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 4) == 0) begin
                    nxt[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 31) == 0) nxt = '0;
            req = nxt;
            model_step(req, reset, lock);
            tick();
            exp_gnt  = m_valid ? (NREQ'(1) << m_sel) : '0;
            exp_dout = m_valid ? din_arr[m_sel] : '0;
            checks++;
            if (gnt !== exp_gnt || valid !== m_valid || sel !== SW'(m_sel) || dout !== exp_dout) begin
                errors++;
                $display("FAIL random c%0d: gnt=%h sel=%0d valid=%b dout=%h, want %h/%0d/%b/%h",
                         cyc, gnt, sel, valid, dout, exp_gnt, m_sel, m_valid, exp_dout);
            end
        end
        reset = 1'b0;
        lock  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = 1'b0;
        for (int i = 0; i < NREQ; i++) din_arr[i] = '0;
        tick();
        test_reset();
        test_single_request();
        test_rotation();
        test_fairness();
        test_lone_requester();
        test_reset_mid_grant();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one N-to-1 mux datapath between NREQ requesters.
- Drives the mux select index, the one-hot (decoder-style) grant vector and the selected data output.
- Fairness comes from a rotating priority pointer plus a bounded hold time.
- Sits in front of the shared mux tree; requesters hold req until served.

Parameters:
- NREQ, 8, number of requesters; legal 2..8. Non-power-of-2 values are allowed; unused select codes are never produced.
- DW, 1, data width per requester.
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester waits; 0 = unlimited.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; held high until served.
- din  input  NREQ*DW  packed requester data; requester i occupies din[i*DW +: DW].
- gnt  output  NREQ  one-hot grant, registered.
- sel  output  $clog2(NREQ)  binary index of the granted requester, registered.
- valid  output  1  high when a grant is active, registered.
- dout  output  DW  din slice of sel when valid, else 0; combinational from registered sel/valid.
- lock  input  1  present only with ARB_LOCK_EN; see Optional Feature.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - Outputs: gnt=0, sel=0, valid=0, dout=0.
  - Internal: state=IDLE, ptr=NREQ-1, hold_cnt=0.
  - Effect: requester 0 has top priority on the first arbitration.
- FSM states: IDLE, GRANT.
- Winner selection:
  - Scan from ptr+1 upward, wrapping modulo NREQ; the first index with req high wins.
  - On every new grant: ptr <= winner, sel <= winner, gnt <= 1<<winner, valid <= 1, hold_cnt <= 1.
- IDLE:
  - req==0: stay in IDLE, outputs remain 0.
  - req!=0 at edge k: grant the winner. gnt/valid/sel are visible after edge k. Latency is 1 cycle from req sampled to gnt.
- GRANT, evaluated each edge, in priority order:
  1. req[sel]==0 (release):
     - Other requests pending: regrant the next winner, scanning from sel+1, on the same edge. No bubble cycle.
     - None pending: go to IDLE; gnt=0, valid=0, sel holds its last value.
  2. MAX_HOLD!=0, hold_cnt==MAX_HOLD, and req has another bit set besides req[sel]: preempt. Grant the next winner from sel+1. The preempted requester keeps requesting and is rescanned in turn.
  3. Otherwise: keep the grant. hold_cnt increments and saturates at MAX_HOLD (width $clog2(MAX_HOLD+1), minimum 1).
- Grant invariants:
  - A lone requester keeps its grant indefinitely.
  - gnt is always one-hot or zero.
  - sel always equals the index of the gnt bit while valid=1.
- req bits at or above NREQ do not exist; din is never indexed out of range.
- Reset mid-grant: the next edge clears all state. No partial grant survives.
- Simultaneous release by the granted requester and a new request: covered by rule 1. The new request is eligible on the same edge.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - The lock input port exists.
  - While valid=1 and lock=1, rule 2 (preemption) is suppressed; release (rule 1) still applies.
  - hold_cnt keeps saturating.
  - Preemption resumes on the first edge where lock=0 and hold_cnt==MAX_HOLD.
- Undefined: no lock port; behaviour exactly as above.

Test Plan:
- Single request: reset, then req=8'h01, din[0]=1 -> one cycle later gnt=8'h01, sel=0, valid=1, dout=1. Drop req -> next cycle gnt=0, valid=0, dout=0.
- Release and rotation: from IDLE after reset, req=8'h84 -> gnt=8'h04, sel=2. Drop req[2] -> next cycle gnt=8'h80, sel=7, valid stays 1 with no bubble.
- Fairness under full load: req=8'hFF held, MAX_HOLD=4 -> grants 0,1,...,7,0 in order, each exactly 4 cycles. valid never drops.
- Lone requester: req=8'h20 held for 20 cycles -> gnt=8'h20 for all 20 cycles, no preemption. hold_cnt saturated at 4.
- Reset mid-grant: reset pulsed during grant to requester 5 -> next edge gnt=0, valid=0, sel=0. Then req=8'hFF -> requester 0 granted first.
- ARB_LOCK_EN defined: req=8'hFF, lock=1 -> requester 0 keeps its grant past 4 cycles. Deassert lock at cycle 10 -> next edge gnt=8'h02.
